// File: rtl/mast_rx_byte_ctrl.sv
// -----------------------------------------------------------------------------
// mast_rx_byte_ctrl
//
// Master-side read-byte sequencer for the I2C master. It turns SDA samples
// taken at SCL mid-high into the shift strobe and serial bit for the master
// SIPO data register, counts the 8 data bits, and drives ACK/NACK during the
// 9th bit. Once the byte is complete it captures the SIPO parallel output into
// a holding register and offers it to the host over a valid/ready handshake.
//
// Optional build macro:
//   MAST_RX_GLITCH_CHK_EN - when defined, SDA is compared against the level
//   recorded at each sample_tick until the following fall_tick. A change while
//   SCL is high aborts the read and sets the sticky master_bus_err. When not
//   defined, master_bus_err is tied to 0 and no comparison logic is built.
//
// Parameters:
//   WDOG_CYC  clock cycles without any tick while busy before the read is
//             aborted (minimum 4).
//
// Ports:
//   master_scl_sixt        in   system clock, all logic on its rising edge
//   master_rst_n           in   synchronous active-low reset
//   master_rd_start        in   one-cycle request to receive one byte
//   master_rd_last         in   sampled with rd_start: 1 = NACK, 0 = ACK
//   master_sda_in          in   synchronised SDA level
//   master_sample_tick     in   one-cycle pulse at SCL mid-high
//   master_fall_tick       in   one-cycle pulse at SCL falling edge
//   master_data_out[7:0]   in   parallel output of the SIPO register
//   master_serial_in       out  registered SDA sample for the SIPO
//   master_rec_data_shift  out  registered one-cycle shift strobe for the SIPO
//   master_sda_drive_low   out  1 = pull SDA low (ACK)
//   master_busy            out  a read is in progress
//   master_byte_done       out  one-cycle pulse at the end of the ACK/NACK bit
//   master_rx_data[7:0]    out  holding register
//   master_rx_valid        out  holding register contains an unread byte
//   master_rx_ready        in   consumer takes the byte when valid && ready
//   master_rx_overrun      out  sticky: a byte was dropped (valid still high)
//   master_timeout         out  one-cycle pulse on watchdog abort
//   master_bus_err         out  sticky SDA-changed-while-SCL-high flag
// -----------------------------------------------------------------------------
module mast_rx_byte_ctrl #(
    parameter int WDOG_CYC = 1024
) (
    input  logic       master_scl_sixt,
    input  logic       master_rst_n,
    input  logic       master_rd_start,
    input  logic       master_rd_last,
    input  logic       master_sda_in,
    input  logic       master_sample_tick,
    input  logic       master_fall_tick,
    input  logic [7:0] master_data_out,
    output logic       master_serial_in,
    output logic       master_rec_data_shift,
    output logic       master_sda_drive_low,
    output logic       master_busy,
    output logic       master_byte_done,
    output logic [7:0] master_rx_data,
    output logic       master_rx_valid,
    input  logic       master_rx_ready,
    output logic       master_rx_overrun,
    output logic       master_timeout,
    output logic       master_bus_err
);

    localparam int                WDOG_W   = $clog2(WDOG_CYC);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Registers and their next-state values
    // ---------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_bit_cnt;
    logic [3:0]        w_bit_cnt_next;
    logic              r_ack_mode;
    logic              w_ack_mode_next;
    logic              r_first_ack;      // first cycle spent in ACK
    logic              w_first_ack_next;
    logic              r_serial_in;
    logic              w_serial_in_next;
    logic              r_shift;
    logic              w_shift_next;
    logic              r_drive_low;
    logic              w_drive_low_next;
    logic              r_busy;
    logic              w_busy_next;
    logic              r_byte_done;
    logic              w_byte_done_next;
    logic              r_timeout;
    logic              w_timeout_next;
    logic [7:0]        r_rx_data;
    logic [7:0]        w_rx_data_next;
    logic              r_rx_valid;
    logic              w_rx_valid_next;
    logic              r_overrun;
    logic              w_overrun_next;
    logic [WDOG_W-1:0] r_wdog;
    logic [WDOG_W-1:0] w_wdog_next;

    logic w_any_tick;
    logic w_cnt_full;
    logic w_wdog_exp;
    logic w_glitch;
    logic w_abort;
    logic w_capture;

    assign w_any_tick = master_sample_tick | master_fall_tick;
    assign w_cnt_full = (r_bit_cnt == 4'd8);

    // A tick in the same cycle restarts the watchdog rather than expiring it.
    assign w_wdog_exp = r_busy && !w_any_tick && (r_wdog == WDOG_MAX);
    assign w_abort    = w_wdog_exp | w_glitch;

    // ---------------------------------------------------------------------
    // Watchdog: free-runs while busy, restarted by any tick
    // ---------------------------------------------------------------------
    always_comb begin
        w_wdog_next = r_wdog;
        if (!r_busy || w_any_tick) begin
            w_wdog_next = '0;
        end else begin
            w_wdog_next = r_wdog + WDOG_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Optional SDA stability check while SCL is high
    // ---------------------------------------------------------------------
`ifdef MAST_RX_GLITCH_CHK_EN
    logic r_sda_ref;
    logic r_chk_armed;
    logic r_bus_err;

    // The fall_tick cycle itself is excluded: SDA may legally move once SCL
    // has gone low. While we drive ACK the line level is our own, so skip it.
    always_comb begin
        w_glitch = r_chk_armed
                && (r_state != ST_IDLE)
                && !master_fall_tick
                && (master_sda_in != r_sda_ref)
                && !((r_state == ST_ACK) && r_drive_low);
    end

    always_ff @(posedge master_scl_sixt) begin
        if (!master_rst_n) begin
            r_sda_ref   <= 1'b0;
            r_chk_armed <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_bus_err <= r_bus_err | w_glitch;
            if ((r_state == ST_IDLE) || w_abort) begin
                r_chk_armed <= 1'b0;
            end else if (master_sample_tick) begin
                r_chk_armed <= 1'b1;
                r_sda_ref   <= master_sda_in;
            end else if (master_fall_tick) begin
                r_chk_armed <= 1'b0;
            end
        end
    end

    assign master_bus_err = r_bus_err;
`else
    assign w_glitch       = 1'b0;
    assign master_bus_err = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM next-state and control outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt;
        w_ack_mode_next  = r_ack_mode;
        w_first_ack_next = 1'b0;
        w_serial_in_next = r_serial_in;
        w_shift_next     = 1'b0;
        w_drive_low_next = r_drive_low;
        w_busy_next      = r_busy;
        w_byte_done_next = 1'b0;
        w_timeout_next   = 1'b0;
        w_capture        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (master_rd_start) begin
                    w_state_next    = ST_RECV;
                    w_bit_cnt_next  = 4'd0;
                    w_ack_mode_next = ~master_rd_last;
                    w_busy_next     = 1'b1;
                end
            end

            ST_RECV: begin
                // A sample that is acted on wins over a coincident fall.
                if (master_sample_tick && !w_cnt_full) begin
                    w_shift_next     = 1'b1;
                    w_serial_in_next = master_sda_in;
                    w_bit_cnt_next   = r_bit_cnt + 4'd1;
                end else if (master_fall_tick && w_cnt_full) begin
                    w_state_next     = ST_ACK;
                    w_drive_low_next = r_ack_mode;
                    w_first_ack_next = 1'b1;
                end
            end

            ST_ACK: begin
                // Tick spacing guarantees the SIPO has settled by now.
                w_capture = r_first_ack;
                if (master_fall_tick) begin
                    w_state_next     = ST_IDLE;
                    w_drive_low_next = 1'b0;
                    w_byte_done_next = 1'b1;
                    w_busy_next      = 1'b0;
                    w_bit_cnt_next   = 4'd0;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase

        // Abort overrides everything: release SDA, no strobe, no capture.
        if (w_abort) begin
            w_state_next     = ST_IDLE;
            w_bit_cnt_next   = 4'd0;
            w_first_ack_next = 1'b0;
            w_shift_next     = 1'b0;
            w_drive_low_next = 1'b0;
            w_busy_next      = 1'b0;
            w_byte_done_next = 1'b0;
            w_capture        = 1'b0;
            w_timeout_next   = w_wdog_exp;
        end
    end

    // ---------------------------------------------------------------------
    // Holding register and consumer handshake
    // ---------------------------------------------------------------------
    always_comb begin
        w_rx_data_next  = r_rx_data;
        w_rx_valid_next = r_rx_valid;
        w_overrun_next  = r_overrun;

        if (r_rx_valid && master_rx_ready) begin
            w_rx_valid_next = 1'b0;
        end

        // A consumer read in the capture cycle frees the slot for the new byte.
        if (w_capture) begin
            if (!r_rx_valid || master_rx_ready) begin
                w_rx_data_next  = master_data_out;
                w_rx_valid_next = 1'b1;
            end else begin
                w_overrun_next = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge master_scl_sixt) begin
        if (!master_rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_ack_mode  <= 1'b0;
            r_first_ack <= 1'b0;
            r_serial_in <= 1'b0;
            r_shift     <= 1'b0;
            r_drive_low <= 1'b0;
            r_busy      <= 1'b0;
            r_byte_done <= 1'b0;
            r_timeout   <= 1'b0;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_wdog      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_ack_mode  <= w_ack_mode_next;
            r_first_ack <= w_first_ack_next;
            r_serial_in <= w_serial_in_next;
            r_shift     <= w_shift_next;
            r_drive_low <= w_drive_low_next;
            r_busy      <= w_busy_next;
            r_byte_done <= w_byte_done_next;
            r_timeout   <= w_timeout_next;
            r_rx_data   <= w_rx_data_next;
            r_rx_valid  <= w_rx_valid_next;
            r_overrun   <= w_overrun_next;
            r_wdog      <= w_wdog_next;
        end
    end

    assign master_serial_in      = r_serial_in;
    assign master_rec_data_shift = r_shift;
    assign master_sda_drive_low  = r_drive_low;
    assign master_busy           = r_busy;
    assign master_byte_done      = r_byte_done;
    assign master_rx_data        = r_rx_data;
    assign master_rx_valid       = r_rx_valid;
    assign master_rx_overrun     = r_overrun;
    assign master_timeout        = r_timeout;

endmodule
